// File: rtl/bcd_conv_scheduler.sv
// Round-robin shared double-dabble converter: grant -> ack next cycle -> bcd_valid W_BIN cycles after ack.
// Requests are held until ack; define BCD_SAT_EN to clamp operands above 10^N_DIG-1 and raise bcd_ovf.
module bcd_conv_scheduler #(
  parameter int N_REQ = 2,
  parameter int W_BIN = 20,
  parameter int N_DIG = 6,
  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*W_BIN-1:0] bin_in,
  output logic [N_REQ-1:0]       ack,
  output logic                   busy,
  output logic [4*N_DIG-1:0]     bcd_out,
  output logic [ID_W-1:0]        bcd_id,
  output logic                   bcd_valid,
  output logic                   bcd_ovf
);

  localparam int BCD_W = 4 * N_DIG;
  localparam int CNT_W = $clog2(W_BIN + 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [ID_W-1:0]  r_rr_ptr;
  logic [ID_W-1:0]  r_id;
  logic [ID_W-1:0]  r_bcd_id;
  logic [CNT_W-1:0] r_cnt;
  logic [W_BIN-1:0] r_op;
  logic [BCD_W-1:0] r_bcd;
  logic [BCD_W-1:0] r_bcd_out;
  logic [N_REQ-1:0] r_ack;
  logic             r_valid;

  logic             w_gnt_vld;
  logic [ID_W-1:0]  w_gnt_id;
  logic [W_BIN-1:0] w_op_sel;
  logic [W_BIN-1:0] w_op_in;
  logic [BCD_W-1:0] w_bcd_adj;
  logic [BCD_W-1:0] w_bcd_nxt;
  logic             w_last;

  // Smallest rotational distance from r_rr_ptr wins; the descending scan lets it overwrite.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_id  = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      for (int j = 0; j < N_REQ; j++) begin
        if (req[j] && (j == ((int'(r_rr_ptr) + i) % N_REQ))) begin
          w_gnt_vld = 1'b1;
          w_gnt_id  = ID_W'(j);
        end
      end
    end
  end

  always_comb begin
    w_op_sel = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (w_gnt_id == ID_W'(j)) w_op_sel = bin_in[j*W_BIN +: W_BIN];
    end
  end

`ifdef BCD_SAT_EN
  localparam logic [63:0] MAX_VAL = 64'(10 ** N_DIG) - 64'd1;

  logic w_sat;
  logic r_ovf_pend;
  logic r_ovf;

  assign w_sat   = (64'(w_op_sel) > MAX_VAL);
  assign w_op_in = w_sat ? W_BIN'(MAX_VAL) : w_op_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf_pend <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      if (r_state == S_IDLE && w_gnt_vld) r_ovf_pend <= w_sat;
      if (r_state == S_SHIFT && w_last)   r_ovf      <= r_ovf_pend;
    end
  end

  assign bcd_ovf = r_ovf;
`else
  assign w_op_in = w_op_sel;
  assign bcd_ovf = 1'b0;
`endif

  // Add-3 correction on every digit before the shift; 4-bit wrap is intentional.
  always_comb begin
    w_bcd_adj = r_bcd;
    for (int d = 0; d < N_DIG; d++) begin
      if (r_bcd[4*d +: 4] >= 4'd5) w_bcd_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
    end
  end

  assign w_bcd_nxt = {w_bcd_adj[BCD_W-2:0], r_op[W_BIN-1]};
  assign w_last    = (r_cnt == CNT_W'(1));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_gnt_vld) w_state_nxt = S_SHIFT;
      S_SHIFT: if (w_last)    w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr  <= '0;
      r_id      <= '0;
      r_bcd_id  <= '0;
      r_cnt     <= '0;
      r_op      <= '0;
      r_bcd     <= '0;
      r_bcd_out <= '0;
      r_ack     <= '0;
      r_valid   <= 1'b0;
    end else begin
      r_ack   <= '0;
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_gnt_vld) begin
            r_op  <= w_op_in;
            r_bcd <= '0;
            r_id  <= w_gnt_id;
            r_cnt <= CNT_W'(W_BIN);
            r_ack <= N_REQ'(1) << w_gnt_id;
          end
        end
        S_SHIFT: begin
          r_bcd <= w_bcd_nxt;
          r_op  <= {r_op[W_BIN-2:0], 1'b0};
          r_cnt <= r_cnt - CNT_W'(1);
          if (w_last) begin
            r_bcd_out <= w_bcd_nxt;
            r_bcd_id  <= r_id;
            r_valid   <= 1'b1;
          end
        end
        S_DONE: begin
          r_rr_ptr <= (r_id == ID_W'(N_REQ - 1)) ? '0 : r_id + ID_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign ack       = r_ack;
  assign busy      = (r_state != S_IDLE);
  assign bcd_out   = r_bcd_out;
  assign bcd_id    = r_bcd_id;
  assign bcd_valid = r_valid;

endmodule
